// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph, select-code and decoder-state definitions shared by the seven-segment driver and decoder
package seven_seg_pkg;
  localparam logic [7:0] GLYPH_L = 8'hC7;
  localparam logic [7:0] GLYPH_R = 8'hAF;
  localparam logic [7:0] GLYPH_B = 8'h83;
  localparam logic [7:0] GLYPH_F = 8'h8E;
  localparam logic [7:0] GLYPH_NIL = 8'hFF;
  localparam logic [3:0] SEL_LR = 4'b1110;
  localparam logic [3:0] SEL_FB = 4'b1101;
  localparam logic [3:0] SEL_OFF = 4'b1111;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} dec_state_e;
endpackage

// File: rtl/seven_seg_glyph_decode.sv
// seven_seg_glyph_decode: maps one scan sample (sel_i, digit_i) to command bits_o {F,B,L,R} and flags illegal_o
module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] sel_i,
  input  logic [7:0] digit_i,
  output logic [3:0] bits_o,
  output logic       illegal_o
);
  logic lr, fb;
  assign lr = sel_i == SEL_LR;
  assign fb = sel_i == SEL_FB;
  assign bits_o = {fb && digit_i == GLYPH_F, fb && digit_i == GLYPH_B,
                   lr && digit_i == GLYPH_L, lr && digit_i == GLYPH_R};
  assign illegal_o = sel_i != SEL_OFF && bits_o == 4'b0;
endmodule

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: snoops the SEL/DIGIT scan bus (sel_i, digit_i) and publishes a window-debounced command_o with cmd_update_o, locked_o and err_count_o
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int WINDOW = 2,
  parameter int STABLE_WINDOWS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] sel_i,
  input  logic [7:0] digit_i,
  output logic [3:0] command_o,
  output logic       cmd_update_o,
  output logic       locked_o,
  output logic [7:0] err_count_o
);
  localparam int WW = WINDOW > 1 ? $clog2(WINDOW) : 1;
  localparam int SW = $clog2(STABLE_WINDOWS + 1);
  dec_state_e state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [SW-1:0] stab_q, stab_d, hits;
  logic [3:0] acc_q, acc_d, cand_q, cand_d, command_q, command_d, bits, wv;
  logic [7:0] err_q, err_d;
  logic upd_q, upd_d, illegal, win_end, stable;
  seven_seg_glyph_decode u_dec (
    .sel_i    (sel_i),
    .digit_i  (digit_i),
    .bits_o   (bits),
    .illegal_o(illegal)
  );
  assign win_end = win_q == WW'(WINDOW - 1);
  assign wv = acc_q | bits;
  assign hits = wv == cand_q ? (stab_q == SW'(STABLE_WINDOWS) ? stab_q : stab_q + 1'b1) : SW'(1);
  assign stable = hits == SW'(STABLE_WINDOWS);
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    acc_d = acc_q;
    cand_d = cand_q;
    stab_d = stab_q;
    command_d = command_q;
    upd_d = 1'b0;
    err_d = illegal && err_q != 8'hFF ? err_q + 8'd1 : err_q;
    if (state_q == IDLE) begin
      state_d = ACQUIRE;
      win_d = '0;
      acc_d = '0;
    end else begin
      win_d = win_end ? '0 : win_q + 1'b1;
      acc_d = win_end ? 4'b0 : wv;
      if (win_end) begin
        cand_d = wv;
        stab_d = hits;
        state_d = stable ? LOCKED : ACQUIRE;
        command_d = stable ? wv : command_q;
        upd_d = stable && wv != command_q;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      win_q <= '0;
      acc_q <= '0;
      cand_q <= '0;
      stab_q <= '0;
      command_q <= '0;
      upd_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      acc_q <= acc_d;
      cand_q <= cand_d;
      stab_q <= stab_d;
      command_q <= command_d;
      upd_q <= upd_d;
      err_q <= err_d;
    end
  end
  assign command_o = command_q;
  assign cmd_update_o = upd_q;
  assign locked_o = state_q == LOCKED;
  assign err_count_o = err_q;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: table-driven and directed self-checking bench for seven_seg_scan_decoder
module tb_seven_seg_scan_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sel = 4'b1111;
  logic [7:0] dig = 8'hFF;
  logic [3:0] command;
  logic cmd_update, locked;
  logic [7:0] err_count;
  int pass_cnt = 0;
  int total_cnt = 0;
  int pulses = 0;
  logic locked_seen = 1'b0;
  typedef struct {
    logic [3:0] sa;
    logic [7:0] da;
    logic [3:0] sb;
    logic [7:0] db;
    logic [3:0] cmd;
    logic [7:0] err;
  } vec_t;
  vec_t tbl [10];
  seven_seg_scan_decoder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sel_i       (sel),
    .digit_i     (dig),
    .command_o   (command),
    .cmd_update_o(cmd_update),
    .locked_o    (locked),
    .err_count_o (err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic step(input logic [3:0] s, input logic [7:0] d);
    sel = s;
    dig = d;
    @(posedge clk);
    #1;
    if (cmd_update) pulses++;
    if (locked) locked_seen = 1'b1;
  endtask
  task automatic win(input logic [3:0] sa, input logic [7:0] da, input logic [3:0] sb, input logic [7:0] db);
    step(sa, da);
    step(sb, db);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    sel = 4'b1111;
    dig = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    locked_seen = 1'b0;
  endtask
  initial begin
    tbl[0] = '{4'b1110, 8'hAF, 4'b1101, 8'h83, 4'b0101, 8'd0};
    tbl[1] = '{4'b1110, 8'hC7, 4'b1101, 8'h8E, 4'b1010, 8'd0};
    tbl[2] = '{4'b1110, 8'hAF, 4'b1111, 8'h00, 4'b0001, 8'd0};
    tbl[3] = '{4'b1111, 8'hFF, 4'b1101, 8'h8E, 4'b1000, 8'd0};
    tbl[4] = '{4'b1110, 8'hFF, 4'b1101, 8'h83, 4'b0100, 8'd4};
    tbl[5] = '{4'b1100, 8'hAF, 4'b1101, 8'h8E, 4'b1000, 8'd4};
    tbl[6] = '{4'b1101, 8'hAF, 4'b1110, 8'h83, 4'b0000, 8'd8};
    tbl[7] = '{4'b1011, 8'hC7, 4'b1111, 8'hFF, 4'b0000, 8'd4};
    tbl[8] = '{4'b1110, 8'hC7, 4'b1110, 8'hC7, 4'b0010, 8'd0};
    tbl[9] = '{4'b1101, 8'h83, 4'b1101, 8'h8E, 4'b1100, 8'd0};
    #2;
    chk("rst_cmd", 8'(command), 8'h0);
    chk("rst_upd", 8'(cmd_update), 8'h0);
    chk("rst_locked", 8'(locked), 8'h0);
    chk("rst_err", err_count, 8'h0);
    for (int i = 0; i < 10; i++) begin
      do_reset();
      step(4'b1111, 8'hFF);
      for (int w = 0; w < 3; w++) win(tbl[i].sa, tbl[i].da, tbl[i].sb, tbl[i].db);
      chk($sformatf("tbl%0d_cmd_early", i), 8'(command), 8'h0);
      win(tbl[i].sa, tbl[i].da, tbl[i].sb, tbl[i].db);
      chk($sformatf("tbl%0d_cmd", i), 8'(command), 8'(tbl[i].cmd));
      chk($sformatf("tbl%0d_upd", i), 8'(cmd_update), 8'(tbl[i].cmd != 4'b0));
      chk($sformatf("tbl%0d_locked", i), 8'(locked), 8'h1);
      chk($sformatf("tbl%0d_err", i), err_count, tbl[i].err);
    end
    do_reset();
    for (int i = 0; i < 3; i++) win(4'b1110, 8'hAF, 4'b1101, 8'h83);
    step(4'b1110, 8'hAF);
    do_reset();
    step(4'b1111, 8'hFF);
    for (int w = 0; w < 3; w++) win(4'b1110, 8'hAF, 4'b1101, 8'h83);
    step(4'b1110, 8'hAF);
    chk("t1_cmd_c8", 8'(command), 8'h0);
    chk("t1_upd_c8", 8'(cmd_update), 8'h0);
    step(4'b1101, 8'h83);
    chk("t1_cmd_c10", 8'(command), 8'h5);
    chk("t1_upd_c10", 8'(cmd_update), 8'h1);
    step(4'b1110, 8'hAF);
    chk("t1_upd_c11", 8'(cmd_update), 8'h0);
    chk("t1_locked", 8'(locked), 8'h1);
    step(4'b1101, 8'h83);
    pulses = 0;
    win(4'b1110, 8'hC7, 4'b1111, 8'hFF);
    chk("t2_locked_drop", 8'(locked), 8'h0);
    win(4'b1110, 8'hC7, 4'b1111, 8'hFF);
    win(4'b1110, 8'hC7, 4'b1111, 8'hFF);
    chk("t2_cmd_hold", 8'(command), 8'h5);
    win(4'b1110, 8'hC7, 4'b1111, 8'hFF);
    chk("t2_cmd", 8'(command), 8'h2);
    for (int w = 0; w < 3; w++) win(4'b1110, 8'hC7, 4'b1111, 8'hFF);
    chk("t2_pulses", 8'(pulses), 8'h1);
    chk("t2_locked", 8'(locked), 8'h1);
    do_reset();
    for (int i = 0; i < 9; i++) step(4'b1111, 8'hFF);
    chk("t3_locked", 8'(locked), 8'h1);
    for (int i = 0; i < 11; i++) step(4'b1111, 8'hFF);
    chk("t3_cmd", 8'(command), 8'h0);
    chk("t3_pulses", 8'(pulses), 8'h0);
    do_reset();
    step(4'b1111, 8'hFF);
    win(4'b1100, 8'hAF, 4'b1101, 8'h83);
    win(4'b1110, 8'hFF, 4'b1101, 8'h83);
    win(4'b1111, 8'hFF, 4'b1101, 8'h83);
    win(4'b1111, 8'hFF, 4'b1101, 8'h83);
    chk("t4_err2", err_count, 8'd2);
    chk("t4_cmd", 8'(command), 8'h4);
    for (int i = 0; i < 300; i++) step(4'b1100, 8'hAF);
    chk("t4_err_sat", err_count, 8'd255);
    step(4'b0000, 8'h00);
    chk("t4_err_hold", err_count, 8'd255);
    do_reset();
    step(4'b1111, 8'hFF);
    for (int w = 0; w < 5; w++) begin
      win(4'b1110, 8'hAF, 4'b1111, 8'hFF);
      win(4'b1111, 8'hFF, 4'b1101, 8'h8E);
    end
    chk("t5_cmd", 8'(command), 8'h0);
    chk("t5_pulses", 8'(pulses), 8'h0);
    chk("t5_locked", 8'(locked_seen), 8'h0);
    do_reset();
    step(4'b1100, 8'hFF);
    for (int w = 0; w < 4; w++) win(4'b1110, 8'hC7, 4'b1101, 8'h8E);
    chk("t6_cmd_pre", 8'(command), 8'hA);
    chk("t6_err_pre", err_count, 8'd1);
    step(4'b1110, 8'hC7);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_cmd", 8'(command), 8'h0);
    chk("t6_async_locked", 8'(locked), 8'h0);
    chk("t6_async_err", err_count, 8'h0);
    chk("t6_async_upd", 8'(cmd_update), 8'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    step(4'b1111, 8'hFF);
    for (int w = 0; w < 3; w++) win(4'b1110, 8'hC7, 4'b1101, 8'h8E);
    chk("t6_reacq_early", 8'(command), 8'h0);
    win(4'b1110, 8'hC7, 4'b1101, 8'h8E);
    chk("t6_reacq_cmd", 8'(command), 8'hA);
    chk("t6_reacq_pulses", 8'(pulses), 8'h1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
